fft_symbol_scheduler: RTL and testbench

FFT_SYMBOL_SCHEDULER -- requirements
Module: fft_symbol_scheduler

---
 rtl/ofdm_pkg.sv | 20 ++
 rtl/fft_symbol_scheduler.sv | 159 +++++++++++++++
 tb/tb_fft_symbol_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM timing constants and scheduler state encoding, used by the symbol
// scheduler and by fft_demod timing.
package ofdm_pkg;

    localparam int unsigned CP_LEN_DEF        = 18;
    localparam int unsigned CP_LONG_LEN_DEF   = 20;
    localparam int unsigned SYMS_BTWN_SSB_DEF = 280;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP_CP = 2'd1,
        ST_FFT_WIN = 2'd2
    } sched_state_t;

    // Symbol phase inside a 7-symbol group.
    function automatic logic [2:0] phase_step(input logic [2:0] phase);
        return (phase == 3'd6) ? 3'd0 : phase + 3'd1;
    endfunction

endpackage

// File: rtl/fft_symbol_scheduler.sv
// Schedules FFT windows on a time-domain sample stream: skips each cyclic prefix,
// gates FFT_LEN samples per symbol, and re-aligns on every qualified SSB start.
module fft_symbol_scheduler
    import ofdm_pkg::*;
#(
    parameter int unsigned NFFT          = 8,
    parameter int unsigned CP_LEN        = CP_LEN_DEF,
    parameter int unsigned CP_LONG_LEN   = CP_LONG_LEN_DEF,
    parameter int unsigned CP_ADVANCE    = 9,
    parameter int unsigned SYMS_BTWN_SSB = SYMS_BTWN_SSB_DEF,
    parameter int unsigned LONG_CP_PHASE = 7
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic                             s_axis_in_tvalid,
    input  logic                             SSB_start_i,
    output logic                             fft_in_en_o,
    output logic                             sym_start_o,
    output logic [$clog2(SYMS_BTWN_SSB)-1:0] sym_idx_o,
    output logic                             long_cp_o,
    output logic                             busy_o,
    output logic                             resync_o
);

    localparam int unsigned FFT_LEN = 2 ** NFFT;
    localparam int unsigned SYM_W   = $clog2(SYMS_BTWN_SSB);
    localparam int unsigned CP_W    = $clog2(CP_LONG_LEN + 1);

    localparam logic [CP_W-1:0]  CP_FIRST = CP_W'(CP_LEN - CP_ADVANCE);
    localparam logic [CP_W-1:0]  CP_NORM  = CP_W'(CP_LEN);
    localparam logic [CP_W-1:0]  CP_LONG  = CP_W'(CP_LONG_LEN);
    localparam logic [NFFT-1:0]  WIN_LAST = NFFT'(FFT_LEN - 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMS_BTWN_SSB - 1);
    localparam logic [2:0]       LC_PHASE = 3'(LONG_CP_PHASE);

    if (CP_ADVANCE >= CP_LEN || CP_LONG_LEN < CP_LEN) begin : g_bad_cp
        $error("fft_symbol_scheduler: need CP_ADVANCE < CP_LEN and CP_LONG_LEN >= CP_LEN");
    end

    sched_state_t     state_q, state_d;
    logic [CP_W-1:0]  cp_cnt_q, cp_cnt_d;
    logic [NFFT-1:0]  win_cnt_q, win_cnt_d;
    logic [SYM_W-1:0] sym_idx_q, sym_idx_d;
    logic [2:0]       phase_q, phase_d;

    logic             start;
    logic             long_cp;
    logic [CP_W-1:0]  cp_target;
    logic [CP_W-1:0]  cp_inc;

    logic             fft_en_d;
    logic             sym_start_d;
    logic             resync_d;
    logic [SYM_W-1:0] sym_idx_out_d;
    logic             long_cp_out_d;

    assign start     = s_axis_in_tvalid && SSB_start_i;
    assign long_cp   = (phase_q == LC_PHASE);
    assign cp_inc    = cp_cnt_q + CP_W'(1);
    assign cp_target = (sym_idx_q == '0) ? CP_FIRST : (long_cp ? CP_LONG : CP_NORM);

    // State and counter register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ST_IDLE;
            cp_cnt_q  <= '0;
            win_cnt_q <= '0;
            sym_idx_q <= '0;
            phase_q   <= '0;
        end else begin
            state_q   <= state_d;
            cp_cnt_q  <= cp_cnt_d;
            win_cnt_q <= win_cnt_d;
            sym_idx_q <= sym_idx_d;
            phase_q   <= phase_d;
        end
    end

    // Next state, counters and per-sample outputs; everything holds on invalid cycles.
    always_comb begin
        state_d       = state_q;
        cp_cnt_d      = cp_cnt_q;
        win_cnt_d     = win_cnt_q;
        sym_idx_d     = sym_idx_q;
        phase_d       = phase_q;
        fft_en_d      = 1'b0;
        sym_start_d   = 1'b0;
        resync_d      = 1'b0;
        sym_idx_out_d = sym_idx_o;
        long_cp_out_d = long_cp_o;

        if (start) begin
            // The SSB sample itself is the first skipped prefix sample.
            resync_d      = (state_q != ST_IDLE);
            sym_idx_d     = '0;
            phase_d       = '0;
            cp_cnt_d      = CP_W'(1);
            win_cnt_d     = '0;
            state_d       = (CP_FIRST <= CP_W'(1)) ? ST_FFT_WIN : ST_SKIP_CP;
            sym_idx_out_d = '0;
            long_cp_out_d = (LC_PHASE == 3'd0);
        end else if (s_axis_in_tvalid) begin
            sym_idx_out_d = sym_idx_q;
            long_cp_out_d = (state_q != ST_IDLE) && long_cp;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SKIP_CP: begin
                    if (cp_inc >= cp_target) begin
                        state_d   = ST_FFT_WIN;
                        win_cnt_d = '0;
                    end else begin
                        cp_cnt_d = cp_inc;
                    end
                end
                ST_FFT_WIN: begin
                    fft_en_d    = 1'b1;
                    sym_start_d = (win_cnt_q == '0);
                    if (win_cnt_q == WIN_LAST) begin
                        phase_d = phase_step(phase_q);
                        if (sym_idx_q == SYM_LAST) begin
                            state_d = ST_IDLE;
                        end else begin
                            sym_idx_d = sym_idx_q + SYM_W'(1);
                            cp_cnt_d  = '0;
                            state_d   = ST_SKIP_CP;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + NFFT'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output register: one cycle behind the sample it describes.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fft_in_en_o <= 1'b0;
            sym_start_o <= 1'b0;
            sym_idx_o   <= '0;
            long_cp_o   <= 1'b0;
            busy_o      <= 1'b0;
            resync_o    <= 1'b0;
        end else begin
            fft_in_en_o <= fft_en_d;
            sym_start_o <= sym_start_d;
            sym_idx_o   <= sym_idx_out_d;
            long_cp_o   <= long_cp_out_d;
            busy_o      <= (state_d != ST_IDLE);
            resync_o    <= resync_d;
        end
    end

endmodule

// File: tb/tb_fft_symbol_scheduler.sv
// Directed bench for fft_symbol_scheduler: a default instance and a short-window
// instance (NFFT=4, long CP on phase 0) share the same sample stream.
module tb_fft_symbol_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       ssb;

    logic       fft_en, sym_start, long_cp, busy, resync;
    logic [8:0] sym_idx;
    logic       fft_en_s, sym_start_s, long_cp_s, busy_s, resync_s;
    logic [8:0] sym_idx_s;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fft_symbol_scheduler dut (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .s_axis_in_tvalid (valid),
        .SSB_start_i      (ssb),
        .fft_in_en_o      (fft_en),
        .sym_start_o      (sym_start),
        .sym_idx_o        (sym_idx),
        .long_cp_o        (long_cp),
        .busy_o           (busy),
        .resync_o         (resync)
    );

    fft_symbol_scheduler #(
        .NFFT          (4),
        .LONG_CP_PHASE (0)
    ) dut_s (
        .clk_i            (clk),
        .reset_ni         (rst_n),
        .s_axis_in_tvalid (valid),
        .SSB_start_i      (ssb),
        .fft_in_en_o      (fft_en_s),
        .sym_start_o      (sym_start_s),
        .sym_idx_o        (sym_idx_s),
        .long_cp_o        (long_cp_s),
        .busy_o           (busy_s),
        .resync_o         (resync_s)
    );

    // Apply one cycle of input; outputs for that sample are visible on return.
    task automatic step(input logic v, input logic s);
        valid = v;
        ssb   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        valid = 1'b0;
        ssb   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        valid = 1'b1;
        ssb   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({fft_en, sym_start, sym_idx, long_cp, busy, resync} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_dut: got %h want 0", {fft_en, sym_start, sym_idx, long_cp, busy, resync});
        end
        vectors++;
        if ({fft_en_s, sym_start_s, sym_idx_s, long_cp_s, busy_s, resync_s} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_dut_s: got %h want 0", {fft_en_s, sym_start_s, sym_idx_s, long_cp_s, busy_s, resync_s});
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0);
            vectors++;
            if ({fft_en, sym_start, busy, fft_en_s, busy_s} !== 5'd0) begin
                miscompares++;
                $display("FAIL idle_no_ssb k=%0d: got en=%0b st=%0b busy=%0b want 0", k, fft_en, sym_start, busy);
            end
        end
    endtask

    task automatic test_continuous;
        logic exp_en, exp_st;
        do_reset();
        for (int k = 0; k <= 290; k++) begin
            step(1'b1, k == 0);
            exp_en = (k >= 9 && k <= 264) || k >= 283;
            exp_st = (k == 9) || (k == 283);
            vectors++;
            if (fft_en !== exp_en || sym_start !== exp_st) begin
                miscompares++;
                $display("FAIL cont_window k=%0d: got en=%0b st=%0b want en=%0b st=%0b", k, fft_en, sym_start, exp_en, exp_st);
            end
            if (k == 0 || k == 100) begin
                vectors++;
                if (busy !== 1'b1 || sym_idx !== 9'd0 || long_cp !== 1'b0) begin
                    miscompares++;
                    $display("FAIL cont_sym0 k=%0d: got busy=%0b idx=%0d lc=%0b want 1,0,0", k, busy, sym_idx, long_cp);
                end
            end
        end
        vectors++;
        if (sym_idx !== 9'd1 || resync !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_sym1: got idx=%0d resync=%0b want idx=1 resync=0", sym_idx, resync);
        end
    endtask

    task automatic test_gapped;
        logic exp_en, exp_st;
        do_reset();
        for (int k = 0; k <= 290; k++) begin
            step(1'b0, k == 100);
            vectors++;
            if (fft_en !== 1'b0 || sym_start !== 1'b0 || resync !== 1'b0) begin
                miscompares++;
                $display("FAIL gap_invalid k=%0d: got en=%0b st=%0b rs=%0b want 0", k, fft_en, sym_start, resync);
            end
            step(1'b1, k == 0);
            exp_en = (k >= 9 && k <= 264) || k >= 283;
            exp_st = (k == 9) || (k == 283);
            vectors++;
            if (fft_en !== exp_en || sym_start !== exp_st) begin
                miscompares++;
                $display("FAIL gap_window k=%0d: got en=%0b st=%0b want en=%0b st=%0b", k, fft_en, sym_start, exp_en, exp_st);
            end
        end
    endtask

    task automatic test_long_cp;
        do_reset();
        for (int k = 0; k <= 1930; k++) begin
            step(1'b1, k == 0);
            if (k == 9 || k == 43 || k == 213 || k == 249 || k == 283) begin
                vectors++;
                if (sym_start_s !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lc_start k=%0d: got %0b want 1", k, sym_start_s);
                end
            end
            if (k == 247 || k == 248 || k == 265) begin
                vectors++;
                if (fft_en_s !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lc_skip k=%0d: got en=%0b want 0", k, fft_en_s);
                end
            end
            if (k == 249) begin
                vectors++;
                if (long_cp_s !== 1'b1 || sym_idx_s !== 9'd7) begin
                    miscompares++;
                    $display("FAIL lc_sym7: got lc=%0b idx=%0d want lc=1 idx=7", long_cp_s, sym_idx_s);
                end
            end
            if (k == 213 || k == 283) begin
                vectors++;
                if (long_cp_s !== 1'b0) begin
                    miscompares++;
                    $display("FAIL lc_normal k=%0d: got %0b want 0", k, long_cp_s);
                end
            end
            if (k == 1908 || k == 1909 || k == 1926 || k == 1927) begin
                vectors++;
                if (fft_en !== (k == 1908 || k == 1927) || sym_start !== (k == 1927) || long_cp !== 1'b0) begin
                    miscompares++;
                    $display("FAIL nolc_sym7 k=%0d: got en=%0b st=%0b lc=%0b", k, fft_en, sym_start, long_cp);
                end
            end
        end
        vectors++;
        if (sym_idx !== 9'd7) begin
            miscompares++;
            $display("FAIL nolc_idx: got %0d want 7", sym_idx);
        end
    endtask

    task automatic test_full_burst;
        int wins;
        int ens;
        int k_end;
        wins  = 0;
        ens   = 0;
        k_end = -1;
        do_reset();
        for (int k = 0; k < 12000 && k_end < 0; k++) begin
            step(1'b1, k == 0);
            wins += int'(sym_start_s);
            ens  += int'(fft_en_s);
            if (k > 0 && busy_s === 1'b0) k_end = k;
        end
        vectors++;
        if (k_end !== 9588) begin
            miscompares++;
            $display("FAIL burst_end: got k=%0d want 9588 (-1 means timeout)", k_end);
        end
        vectors++;
        if (wins !== 280 || ens !== 4480) begin
            miscompares++;
            $display("FAIL burst_count: got wins=%0d ens=%0d want 280 4480", wins, ens);
        end
        ens = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b1, 1'b0);
            ens += int'(fft_en_s) + int'(busy_s);
        end
        vectors++;
        if (ens !== 0) begin
            miscompares++;
            $display("FAIL burst_after: got %0d active cycles want 0", ens);
        end
    endtask

    task automatic test_resync;
        int pulses;
        pulses = 0;
        do_reset();
        for (int k = 0; k <= 1000; k++) begin
            step(1'b1, k == 0 || k == 931);
            pulses += int'(resync);
            if (k == 930) begin
                vectors++;
                if (sym_idx !== 9'd3 || fft_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rs_before: got idx=%0d en=%0b want 3 1", sym_idx, fft_en);
                end
            end
            if (k == 931) begin
                vectors++;
                if (resync !== 1'b1 || fft_en !== 1'b0 || sym_idx !== 9'd0 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rs_pulse: got rs=%0b en=%0b idx=%0d busy=%0b want 1 0 0 1", resync, fft_en, sym_idx, busy);
                end
            end
            if (k == 939 || k == 940) begin
                vectors++;
                if (fft_en !== (k == 940) || sym_start !== (k == 940) || sym_idx !== 9'd0) begin
                    miscompares++;
                    $display("FAIL rs_rewin k=%0d: got en=%0b st=%0b idx=%0d", k, fft_en, sym_start, sym_idx);
                end
            end
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++;
            $display("FAIL rs_count: got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid;
        logic exp_en, exp_st;
        do_reset();
        for (int k = 0; k <= 59; k++) step(1'b1, k == 0);
        vectors++;
        if (fft_en !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_pre: got en=%0b want 1", fft_en);
        end
        ssb = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({fft_en, sym_start, sym_idx, long_cp, busy, resync} !== 14'd0) begin
                miscompares++;
                $display("FAIL rm_in_reset c=%0d: got %h want 0", c, {fft_en, sym_start, sym_idx, long_cp, busy, resync});
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0);
            vectors++;
            if (fft_en !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rm_no_resume k=%0d: got en=%0b busy=%0b want 0", k, fft_en, busy);
            end
        end
        for (int k = 0; k <= 290; k++) begin
            step(1'b1, k == 0);
            exp_en = (k >= 9 && k <= 264) || k >= 283;
            exp_st = (k == 9) || (k == 283);
            vectors++;
            if (fft_en !== exp_en || sym_start !== exp_st) begin
                miscompares++;
                $display("FAIL rm_window k=%0d: got en=%0b st=%0b want en=%0b st=%0b", k, fft_en, sym_start, exp_en, exp_st);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        ssb   = 1'b0;
        test_reset();
        test_continuous();
        test_gapped();
        test_long_cp();
        test_full_burst();
        test_resync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
